// File: rtl/demuxb_reg.sv
// rtl/demuxb_reg.sv - registered 1:2 demultiplexer with a 2-entry FIFO and delivered-word counter per channel
module demuxb_reg #(
    parameter int W  = 4,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    input  logic          in_sel,
    output logic          y0_valid,
    input  logic          y0_ready,
    output logic [W-1:0]  y0_data,
    output logic          y1_valid,
    input  logic          y1_ready,
    output logic [W-1:0]  y1_data,
    output logic [CW-1:0] cnt0,
    output logic [CW-1:0] cnt1
);

    logic [1:0]    occ  [2];
    logic [W-1:0]  head [2];
    logic [W-1:0]  tail [2];
    logic [CW-1:0] cnt  [2];
    logic [1:0]    push;
    logic [1:0]    pop;
    logic [1:0]    y_ready;

    assign y_ready = {y1_ready, y0_ready};

    // Readiness looks only at the selected channel's registered occupancy;
    // a full channel refuses even if it is being popped this cycle.
    assign in_ready = in_sel ? (occ[1] != 2'd2) : (occ[0] != 2'd2);

    always_comb begin
        push = '0;
        pop  = '0;
        push = {in_valid && in_ready && in_sel, in_valid && in_ready && !in_sel};
        pop  = {(occ[1] != 2'd0) && y_ready[1], (occ[0] != 2'd0) && y_ready[0]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                occ[k]  <= 2'd0;
                head[k] <= '0;
                tail[k] <= '0;
                cnt[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (pop[k])
                    cnt[k] <= cnt[k] + 1'b1;
                case ({push[k], pop[k]})
                    2'b10: begin
                        if (occ[k] == 2'd0)
                            head[k] <= in_data;
                        else
                            tail[k] <= in_data;
                        occ[k] <= occ[k] + 2'd1;
                    end
                    2'b01: begin
                        if (occ[k] == 2'd2)
                            head[k] <= tail[k];
                        occ[k] <= occ[k] - 2'd1;
                    end
                    // Push with pop only happens at occupancy 1, so the new word becomes head.
                    2'b11: head[k] <= in_data;
                    default: ;
                endcase
            end
        end
    end

    assign y0_valid = (occ[0] != 2'd0);
    assign y1_valid = (occ[1] != 2'd0);
    assign y0_data  = head[0];
    assign y1_data  = head[1];
    assign cnt0     = cnt[0];
    assign cnt1     = cnt[1];

endmodule

// File: tb/tb_demuxb_reg.sv
// tb/tb_demuxb_reg.sv - self-checking bench for demuxb_reg against a queue-based channel model
module tb_demuxb_reg;

    localparam int W  = 4;
    localparam int CW = 8;

    logic          clk = 0;
    logic          rst_n = 0;
    logic          in_valid = 0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic          in_sel = 0;
    logic          y0_valid, y1_valid;
    logic          y0_ready = 0, y1_ready = 0;
    logic [W-1:0]  y0_data, y1_data;
    logic [CW-1:0] cnt0, cnt1;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    int q0[$];
    int q1[$];
    int m_cnt0 = 0;
    int m_cnt1 = 0;

    demuxb_reg #(.W(W), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel),
        .y0_valid(y0_valid), .y0_ready(y0_ready), .y0_data(y0_data),
        .y1_valid(y1_valid), .y1_ready(y1_ready), .y1_data(y1_data),
        .cnt0(cnt0), .cnt1(cnt1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model comparison on every falling edge while out of reset.
    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            chk("y0_valid", int'(y0_valid), int'(q0.size() != 0));
            chk("y1_valid", int'(y1_valid), int'(q1.size() != 0));
            if (q0.size() != 0) chk("y0_data", int'(y0_data), q0[0]);
            if (q1.size() != 0) chk("y1_data", int'(y1_data), q1[0]);
            chk("cnt0", int'(cnt0), m_cnt0);
            chk("cnt1", int'(cnt1), m_cnt1);
        end
    end

    // One clock cycle of stimulus; rdy returns the in_ready the DUT showed.
    task automatic cycle(input bit v, input int d, input bit s, input bit r0, input bit r1,
                         output bit rdy);
        bit m_rdy, do_push, do_pop0, do_pop1;
        @(negedge clk);
        #2;
        in_valid = v;
        in_data  = W'(d);
        in_sel   = s;
        y0_ready = r0;
        y1_ready = r1;
        #1;
        m_rdy = s ? (q1.size() < 2) : (q0.size() < 2);
        chk("in_ready", int'(in_ready), int'(m_rdy));
        rdy     = in_ready;
        do_push = v && m_rdy;
        do_pop0 = (q0.size() != 0) && r0;
        do_pop1 = (q1.size() != 0) && r1;
        @(posedge clk);
        #1;
        if (do_pop0) begin void'(q0.pop_front()); m_cnt0 = (m_cnt0 + 1) % (1 << CW); end
        if (do_pop1) begin void'(q1.pop_front()); m_cnt1 = (m_cnt1 + 1) % (1 << CW); end
        if (do_push) begin
            if (s) q1.push_back(d % (1 << W));
            else   q0.push_back(d % (1 << W));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        chk_en = 0;
        rst_n  = 0;
        #1;
        chk("rst y0_valid", int'(y0_valid), 0);
        chk("rst y1_valid", int'(y1_valid), 0);
        chk("rst cnt0", int'(cnt0), 0);
        chk("rst cnt1", int'(cnt1), 0);
        in_sel = 0; #1;
        chk("rst in_ready sel0", int'(in_ready), 1);
        in_sel = 1; #1;
        chk("rst in_ready sel1", int'(in_ready), 1);
        q0.delete(); q1.delete();
        m_cnt0 = 0; m_cnt1 = 0;
        in_valid = 0; y0_ready = 0; y1_ready = 0;
        @(negedge clk);
        #2;
        rst_n  = 1;
        chk_en = 1;
    endtask

    initial begin
        bit r;
        int c1_start;
        int vec_d[8]  = '{5, 9, 14, 2, 7, 11, 0, 15};
        int vec_s[8]  = '{0, 1, 1, 0, 0, 1, 0, 1};
        int vec_r0[8] = '{0, 0, 1, 1, 0, 1, 1, 1};
        int vec_r1[8] = '{1, 0, 0, 1, 1, 1, 0, 1};

        do_reset();

        // Steering with both consumers ready.
        cycle(1, 4'h3, 0, 1, 1, r);
        chk("steer y0_valid", int'(y0_valid), 1);
        chk("steer y0_data", int'(y0_data), 3);
        cycle(1, 4'hC, 1, 1, 1, r);
        chk("steer y1_valid", int'(y1_valid), 1);
        chk("steer y1_data", int'(y1_data), 12);
        cycle(0, 0, 0, 1, 1, r);
        chk("steer cnt0", int'(cnt0), 1);
        chk("steer cnt1", int'(cnt1), 1);

        // Backpressure on channel 0, then redirect the stalled word.
        cycle(1, 1, 0, 0, 0, r);
        cycle(1, 2, 0, 0, 0, r);
        cycle(1, 3, 0, 0, 0, r);
        chk("full in_ready", int'(r), 0);
        cycle(1, 3, 1, 0, 0, r);
        chk("redirect in_ready", int'(r), 1);
        chk("redirect y1_data", int'(y1_data), 3);

        // Full channel with a pop in the same cycle refuses the push.
        cycle(1, 4, 0, 1, 0, r);
        chk("fullpop in_ready", int'(r), 0);
        chk("fullpop y0_data", int'(y0_data), 2);
        cycle(1, 4, 0, 1, 0, r);
        chk("fullpop retry", int'(r), 1);
        chk("fullpop y0_data2", int'(y0_data), 4);
        cycle(0, 0, 0, 1, 1, r);
        cycle(0, 0, 0, 1, 1, r);

        // Streaming 0..15 on channel 1 with continuous pops.
        c1_start = m_cnt1;
        for (int i = 0; i < 16; i++) begin
            cycle(1, i, 1, 0, 1, r);
            chk("stream ready", int'(r), 1);
            chk("stream y1_data", int'(y1_data), i);
        end
        cycle(0, 0, 1, 0, 1, r);
        chk("stream cnt1", int'(cnt1), c1_start + 16);
        chk("stream y1_valid", int'(y1_valid), 0);

        // Mixed directed vectors.
        for (int i = 0; i < 8; i++)
            cycle(1, vec_d[i], vec_s[i][0], vec_r0[i][0], vec_r1[i][0], r);

        // Reset with both FIFOs full.
        cycle(1, 6, 0, 0, 0, r);
        cycle(1, 8, 1, 0, 0, r);
        cycle(1, 10, 0, 0, 0, r);
        cycle(1, 12, 1, 0, 0, r);
        chk("prefill y0_valid", int'(y0_valid), 1);
        chk("prefill y1_valid", int'(y1_valid), 1);
        do_reset();

        // Counter wrap: 257 words on channel 0.
        for (int i = 0; i < 257; i++)
            cycle(1, i, 0, 1, 0, r);
        cycle(0, 0, 0, 1, 0, r);
        chk("wrap cnt0", int'(cnt0), 1);
        chk("wrap cnt1", int'(cnt1), 0);

        cycle(0, 0, 0, 0, 0, r);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
